// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wb_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback, auxiliary, issue-scoreboard and register-file port bundle.
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  // Handshakes: wb_wr/wb_ack and aux_valid/aux_ready; a transfer happens in the
  // cycle where both are high. aux_valid must hold with stable addr/data until
  // aux_ready; wb_ack low means the pipeline holds its writeback.
  logic        wb_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        aux_valid;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        iss_busy;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_pipe;
  arb_state_t  state;

  modport slave (
    input  wb_wr, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    input  iss_valid, iss_addr, rs_addr, rt_addr,
    output wb_ack, aux_ready, rs_busy, rt_busy, iss_busy,
    output rf_wr, rf_addr, rf_data, stall_pipe, state
  );

  modport master (
    output wb_wr, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    output iss_valid, iss_addr, rs_addr, rt_addr,
    input  wb_ack, aux_ready, rs_busy, rt_busy, iss_busy,
    input  rf_wr, rf_addr, rf_data, stall_pipe, state
  );
endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-aux-write scoreboard: one bit per architectural register r1..r31.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic [4:0] iss_addr,
  output logic       rs_busy,
  output logic       rt_busy,
  output logic       iss_busy
);
  // Bit 0 is never written, so lookups of r0 read back 0 without a special case.
  logic [31:0] pend;
  logic [31:0] pend_n;

  always_comb begin
    pend_n = pend;
    if (clr_en && clr_addr != REG_ZERO) pend_n[clr_addr] = 1'b0;
    // A new dispatch to the same register outranks the retiring result.
    if (set_en && set_addr != REG_ZERO) pend_n[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= pend_n;
  end

  assign rs_busy  = pend[rs_addr];
  assign rt_busy  = pend[rt_addr];
  assign iss_busy = pend[iss_addr];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: writeback has priority, aux is starvation-protected.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  rf_wb_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             wb_grant;
  logic             aux_grant;

  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    wb_grant  = 1'b0;
    aux_grant = 1'b0;
    if (state == ST_FORCE) begin
      aux_grant = bus.aux_valid;
    end else if (bus.wb_wr) begin
      wb_grant = 1'b1;
    end else begin
      aux_grant = bus.aux_valid;
    end
    // Nothing is acknowledged or written while reset is held.
    if (!reset) begin
      wb_grant  = 1'b0;
      aux_grant = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.wb_wr && bus.aux_valid) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!bus.wb_wr || !bus.aux_valid) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= LIMIT) state <= ST_FORCE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.wb_ack     = wb_grant;
  assign bus.aux_ready  = aux_grant;
  assign bus.stall_pipe = (state == ST_FORCE);
  assign bus.state      = state;
  assign bus.rf_wr      = (wb_grant && bus.wb_addr != REG_ZERO) ||
                          (aux_grant && bus.aux_addr != REG_ZERO);
  assign bus.rf_addr    = aux_grant ? bus.aux_addr : bus.wb_addr;
  assign bus.rf_data    = aux_grant ? bus.aux_data : bus.wb_data;

  rf_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.iss_valid),
    .set_addr (bus.iss_addr),
    .clr_en   (aux_grant),
    .clr_addr (bus.aux_addr),
    .rs_addr  (bus.rs_addr),
    .rt_addr  (bus.rt_addr),
    .iss_addr (bus.iss_addr),
    .rs_busy  (bus.rs_busy),
    .rt_busy  (bus.rt_busy),
    .iss_busy (bus.iss_busy)
  );
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two requesters: the pipeline writeback stage (primary) and a long-latency auxiliary unit such as the multicycle mult/div or the slow peripheral load path (secondary). It also keeps a 31-entry scoreboard of registers awaiting an auxiliary result so that issue logic can stall on RAW and WAW hazards. It sits between the writeback stage, the auxiliary unit and the register file write port (wr/addr3/data3).

Parameters:
STARVE_LIMIT, 4, consecutive cycles an aux request may be denied before the arbiter forces a grant (1..15)
CNT_W, 4, width of the starvation counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
wb_wr  input  1  pipeline writeback write request
wb_addr  input  5  writeback destination register
wb_data  input  32  writeback data
wb_ack  output  1  writeback write performed this cycle; 0 means the pipeline must hold WB
aux_valid  input  1  auxiliary result valid
aux_addr  input  5  auxiliary destination register
aux_data  input  32  auxiliary result
aux_ready  output  1  auxiliary result accepted this cycle
iss_valid  input  1  issue stage dispatches an aux op this cycle
iss_addr  input  5  destination of the dispatched aux op
rs_addr  input  5  issue-stage source register 1
rt_addr  input  5  issue-stage source register 2
rs_busy  output  1  rs_addr has a pending aux write
rt_busy  output  1  rt_addr has a pending aux write
iss_busy  output  1  iss_addr has a pending aux write (WAW)
rf_wr  output  1  to register file wr
rf_addr  output  5  to register file addr3
rf_data  output  32  to register file data3
stall_pipe  output  1  FORCE state active; pipeline freezes

Behaviour:
- Write-port mux is combinational; writes land at the same posedge (0-cycle latency). rf_wr = granted request.
- States: IDLE, WAIT, FORCE (2-bit register); starve counter cnt (CNT_W bits).
- IDLE: wb_wr=1 -> grant WB (wb_ack=1, aux_ready=0). wb_wr=0 & aux_valid=1 -> grant aux. If aux_valid=1 and wb_wr=1 -> go to WAIT, cnt<=1.
- WAIT: wb_wr=0 -> grant aux, go to IDLE, cnt<=0. wb_wr=1 -> grant WB, cnt<=cnt+1; when cnt+1 == STARVE_LIMIT -> go to FORCE. aux_valid dropping (not allowed by protocol) -> IDLE, cnt<=0.
- FORCE: stall_pipe=1; grant aux unconditionally; wb_ack=0 even if wb_wr=1; next state IDLE, cnt<=0. FORCE lasts exactly one cycle.
- Aux protocol: aux_valid held with stable addr/data until aux_ready=1.
- wb_ack = wb_wr when WB granted; wb_ack=0 when wb_wr=0.
- Address 0: a granted request with addr 0 is consumed (ack/ready=1) but rf_wr=0.
- Scoreboard pend[31:1]: iss_valid & iss_addr!=0 sets pend[iss_addr]; an aux grant clears pend[aux_addr]. Same register set and cleared in one cycle -> set wins.
- rs_busy = pend[rs_addr], rt_busy = pend[rt_addr], iss_busy = pend[iss_addr]; all 0 for address 0. Combinational from registered pend; a clear becomes visible the next cycle. The regfile provides the value in that same cycle.
- Issue logic must not dispatch while iss_busy=1. If it does, pend stays 1 and the older result clears it.
- Reset (async, any state): state=IDLE, cnt=0, pend=0. Outputs during reset: stall_pipe=0, aux_ready=0, wb_ack=0, rf_wr=0. An in-flight aux result is dropped unless re-presented.

Decomposition:
- Shared package: state encodings (IDLE=0, WAIT=1, FORCE=2), REG_ZERO=5'd0, default STARVE_LIMIT.
- One sub-module is natural: rf_scoreboard (pend register, set/clear, three busy lookups). The arbiter FSM stays in the top.

Test Plan:
- Reset, no requests -> rf_wr=0, all busy=0, stall_pipe=0; wb_wr=1 addr 5 data 0x1234 -> rf_wr=1, rf_addr=5, wb_ack=1 same cycle.
- iss_valid addr 8 -> rs_addr=8 gives rs_busy=1 next cycle; aux_valid addr 8 data 0xCAFE with wb_wr=0 -> aux_ready=1, rf_data=0xCAFE; rs_busy=0 the following cycle.
- aux_valid held with wb_wr=1 every cycle, STARVE_LIMIT=4 -> WB granted 4 cycles, then 1 cycle with stall_pipe=1, wb_ack=0, aux granted; WB granted again on the next cycle.
- Same cycle: iss_valid addr 3 and aux grant addr 3 -> pend[3] remains 1.
- aux/wb writes to addr 0 -> ack/ready=1, rf_wr=0; iss_valid addr 0 -> no busy bit set.
- reset asserted in FORCE with pend[12]=1 -> immediately IDLE, stall_pipe=0, pend[12]=0.
